// File: rtl/game_flow_ctrl.sv
// Game-level sequencer for the paddle game: serve/play/win/lose flow, score, lives,
// ball gating and the win-letter reveal mask. All timing is counted in frame ticks.
module game_flow_ctrl #(
  parameter int WIN_SCORE     = 10,
  parameter int LIVES         = 3,
  parameter int SERVE_FRAMES  = 60,
  parameter int LETTER_FRAMES = 30,
  parameter int HOLD_FRAMES   = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       ball_hit,
  input  logic       ball_miss,
  output logic       game_run,
  output logic       ball_reset,
  output logic [3:0] score,
  output logic [2:0] lives,
  output logic       win,
  output logic       lose,
  output logic [3:0] letter_mask,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4
  } state_t;

  localparam logic [3:0]  WIN_S       = 4'(WIN_SCORE);
  localparam logic [2:0]  LIVES_I     = 3'(LIVES);
  localparam logic [15:0] SERVE_LAST  = 16'(SERVE_FRAMES - 1);
  localparam logic [15:0] LETTER_LAST = 16'(LETTER_FRAMES - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_FRAMES - 1);

  state_t      st;
  logic [15:0] fcnt;

  assign state = st;

  // fcnt is cleared on every transition; that later assignment overrides the tick
  // increment, so a tick coincident with a state change is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      fcnt        <= '0;
      score       <= '0;
      lives       <= LIVES_I;
      game_run    <= 1'b0;
      ball_reset  <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
      letter_mask <= '0;
    end else begin
      ball_reset <= 1'b0;
      if (frame_tick) fcnt <= fcnt + 16'd1;
      case (st)
        IDLE: begin
          if (start_btn) begin
            st         <= SERVE;
            score      <= '0;
            lives      <= LIVES_I;
            ball_reset <= 1'b1;
            fcnt       <= '0;
          end
        end
        SERVE: begin
          game_run <= 1'b0;
          if (frame_tick && fcnt == SERVE_LAST) begin
            st       <= PLAY;
            game_run <= 1'b1;
            fcnt     <= '0;
          end
        end
        PLAY: begin
          if (ball_miss) begin
            game_run <= 1'b0;
            fcnt     <= '0;
            if (lives <= 3'd1) begin
              lives <= '0;
              lose  <= 1'b1;
              st    <= LOSE;
            end else begin
              lives      <= lives - 3'd1;
              ball_reset <= 1'b1;
              st         <= SERVE;
            end
          end else if (ball_hit && score < WIN_S) begin
            score <= score + 4'd1;
            if (score + 4'd1 == WIN_S) begin
              st          <= WIN;
              win         <= 1'b1;
              letter_mask <= 4'b0001;
              game_run    <= 1'b0;
              fcnt        <= '0;
            end
          end
        end
        WIN: begin
          if (frame_tick) begin
            if (letter_mask != 4'b1111) begin
              // Restart the count per letter; the hold period starts at the last reveal.
              if (fcnt == LETTER_LAST) begin
                letter_mask <= {letter_mask[2:0], 1'b1};
                fcnt        <= '0;
              end
            end else if (fcnt == HOLD_LAST) begin
              st          <= IDLE;
              win         <= 1'b0;
              letter_mask <= '0;
              fcnt        <= '0;
            end
          end
        end
        LOSE: begin
          if (frame_tick && fcnt == HOLD_LAST) begin
            st   <= IDLE;
            lose <= 1'b0;
            fcnt <= '0;
          end
        end
        default: begin
          st          <= IDLE;
          game_run    <= 1'b0;
          win         <= 1'b0;
          lose        <= 1'b0;
          letter_mask <= '0;
          fcnt        <= '0;
        end
      endcase
    end
  end

endmodule
